// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper-motor command path.
// Holds the step-sequencer state encoding, the minimum step spacing, and the
// step/direction types that the sequencer and the stepper state machine both use.
package stepper_pkg;

    // Smallest legal interval between two step strobes, in clock cycles.
    // This value also keeps Step from being high on two consecutive cycles.
    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } seq_state_t;

    // Step strobe and direction as seen by the stepper state machine.
    typedef logic step_strobe_t;
    typedef logic step_dir_t;

    typedef struct packed {
        step_strobe_t step;
        step_dir_t    dir;
    } step_cmd_t;

endpackage

// File: rtl/step_interval_timer.sv
// Interval timer: a down-counter that fires a one-cycle expire pulse a programmed number of cycles after load.
// Latency: a load of value V in cycle c makes expire go high in cycle c+V. A value of 0 leaves the timer disarmed.
// Backpressure: none. A load always takes priority and restarts the count.
// Ports: clk, rst_n (async, active-low); load and value to arm the timer; expire (combinational from the count register).
module step_interval_timer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    // The count reaches 1 exactly V-1 cycles after the load edge.
    // The pulse therefore lands V cycles after the cycle that issued the load.
    assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/step_sequencer.sv
// Step sequencer: on Start, emits StepCount one-cycle Step strobes using a trapezoidal accel/cruise/decel interval profile.
// Latency: the first Step comes one cycle after Start is accepted. Done comes one cycle after the last Step or after Abort.
// Backpressure: Start is ignored while a run or its Done cycle is in progress. Abort ends a run without issuing a Step that cycle.
// Ports: CLOCK_50, RESET_N (async, active-low); Start/Abort/Dir/StepCount/Period command inputs;
//        Step/StepDir to the stepper state machine; Busy/Done/Remaining for status.
module step_sequencer
    import stepper_pkg::*;
#(
    parameter int COUNT_W      = 16,
    parameter int PERIOD_W     = 20,
    parameter int START_PERIOD = 500000,
    parameter int RAMP_DELTA   = 25000
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                Start,
    input  logic                Abort,
    input  logic                Dir,
    input  logic [COUNT_W-1:0]  StepCount,
    input  logic [PERIOD_W-1:0] Period,
    output logic                Step,
    output logic                StepDir,
    output logic                Busy,
    output logic                Done,
    output logic [COUNT_W-1:0]  Remaining
);

    localparam logic [PERIOD_W-1:0] START_P    = PERIOD_W'(START_PERIOD);
    localparam logic [PERIOD_W-1:0] DELTA_P    = PERIOD_W'(RAMP_DELTA);
    localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W:0]   START_WIDE = {1'b0, START_P};
    localparam logic [PERIOD_W:0]   DELTA_WIDE = {1'b0, DELTA_P};

    seq_state_t          state, state_nxt;
    step_dir_t           dir_q, dir_nxt;
    logic [COUNT_W-1:0]  remaining, rem_nxt;
    logic [PERIOD_W-1:0] cur, cur_nxt;        // interval to use after the next Step
    logic [PERIOD_W-1:0] t_q, t_nxt;          // clamped cruise interval for this run
    logic [COUNT_W-1:0]  acc_steps, acc_nxt;  // steps spent accelerating, mirrored on decel
    logic                accel, accel_nxt;

    logic                tmr_load;
    logic [PERIOD_W-1:0] tmr_value;
    logic                tmr_expire;

    logic [PERIOD_W-1:0] t_clamp;
    logic [PERIOD_W:0]   up_sum;
    logic [PERIOD_W:0]   ramp_floor;
    logic [COUNT_W-1:0]  rem_dec;

    step_interval_timer #(
        .WIDTH (PERIOD_W)
    ) u_timer (
        .clk    (CLOCK_50),
        .rst_n  (RESET_N),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    // Ramp arithmetic uses one extra bit. The decel step cannot wrap, and the
    // accel test cur-DELTA >= T is done as cur >= T+DELTA so it never underflows.
    always_comb begin
        t_clamp    = (Period < MIN_P) ? MIN_P : Period;
        up_sum     = {1'b0, cur} + DELTA_WIDE;
        ramp_floor = {1'b0, t_q} + DELTA_WIDE;
        rem_dec    = remaining - COUNT_W'(1);
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_q;
        rem_nxt   = remaining;
        cur_nxt   = cur;
        t_nxt     = t_q;
        acc_nxt   = acc_steps;
        accel_nxt = accel;
        tmr_load  = 1'b0;
        tmr_value = '0;
        Step      = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;

        case (state)
            IDLE: begin
                if (Start) begin
                    dir_nxt   = Dir;
                    rem_nxt   = StepCount;
                    t_nxt     = t_clamp;
                    cur_nxt   = (t_clamp > START_P) ? t_clamp : START_P;
                    acc_nxt   = '0;
                    accel_nxt = 1'b1;
                    if (StepCount == '0) begin
                        state_nxt = FINISH;
                    end else begin
                        // Arm the timer with 1 so the first Step lands on the RUN entry cycle.
                        state_nxt = RUN;
                        tmr_load  = 1'b1;
                        tmr_value = PERIOD_W'(1);
                    end
                end
            end

            RUN: begin
                Busy = 1'b1;
                if (Abort) begin
                    // Disarm the timer so a stale expiry cannot leak into a later run.
                    state_nxt = FINISH;
                    tmr_load  = 1'b1;
                end else if (tmr_expire) begin
                    Step     = 1'b1;
                    rem_nxt  = rem_dec;
                    tmr_load = 1'b1;
                    if (rem_dec == '0) begin
                        state_nxt = FINISH;
                    end else begin
                        if (rem_dec <= acc_steps) begin
                            cur_nxt   = (up_sum > START_WIDE) ? START_P : up_sum[PERIOD_W-1:0];
                            accel_nxt = 1'b0;
                        end else if (accel && ({1'b0, cur} >= ramp_floor)) begin
                            cur_nxt = cur - DELTA_P;
                            acc_nxt = acc_steps + COUNT_W'(1);
                        end else begin
                            cur_nxt   = t_q;
                            accel_nxt = 1'b0;
                        end
                        tmr_value = cur_nxt;
                    end
                end
            end

            FINISH: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            remaining <= '0;
            cur       <= '0;
            t_q       <= '0;
            acc_steps <= '0;
            accel     <= 1'b0;
        end else begin
            state     <= state_nxt;
            dir_q     <= dir_nxt;
            remaining <= rem_nxt;
            cur       <= cur_nxt;
            t_q       <= t_nxt;
            acc_steps <= acc_nxt;
            accel     <= accel_nxt;
        end
    end

    assign StepDir   = dir_q;
    assign Remaining = remaining;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed testbench for step_sequencer with START_PERIOD=8 and RAMP_DELTA=2.
// Covers the ramp, zero-count, constant-spacing, abort, ignored-Start/clamp and mid-run reset scenarios.
// Expected step cycles are counted from the Start cycle (cycle 0).
module tb_step_sequencer;

    logic        CLOCK_50;
    logic        RESET_N;
    logic        Start;
    logic        Abort;
    logic        Dir;
    logic [15:0] StepCount;
    logic [19:0] Period;
    logic        Step;
    logic        StepDir;
    logic        Busy;
    logic        Done;
    logic [15:0] Remaining;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    int step_q[$];
    int rem_q[$];
    int dir_q[$];
    int exp_q[$];
    int done_at;
    int rem_at_done;
    int busy_at_done;
    int busy_hi;
    int consec;
    int quiet;

    step_sequencer #(
        .COUNT_W      (16),
        .PERIOD_W     (20),
        .START_PERIOD (8),
        .RAMP_DELTA   (2)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .Start     (Start),
        .Abort     (Abort),
        .Dir       (Dir),
        .StepCount (StepCount),
        .Period    (Period),
        .Step      (Step),
        .StepDir   (StepDir),
        .Busy      (Busy),
        .Done      (Done),
        .Remaining (Remaining)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present a Start in the current cycle. That cycle becomes relative cycle 0.
    task automatic launch(input logic d, input logic [15:0] n, input logic [19:0] p);
        @(negedge CLOCK_50);
        Dir       = d;
        StepCount = n;
        Period    = p;
        Start     = 1'b1;
        t0        = cyc;
    endtask

    // Observe a run until Done (bounded). Optionally assert Abort or inject a
    // second Start with different command fields in a given relative cycle.
    task automatic capture(input int abort_at, input int inject_at,
                           input logic [15:0] inj_cnt, input logic inj_dir,
                           input logic [19:0] inj_per);
        int rel;
        logic prev;
        step_q.delete();
        rem_q.delete();
        dir_q.delete();
        done_at      = -1;
        rem_at_done  = -1;
        busy_at_done = -1;
        busy_hi      = 0;
        consec       = 0;
        prev         = 1'b0;
        for (int i = 0; i < 200 && done_at < 0; i++) begin
            @(posedge CLOCK_50);
            #1;
            rel   = cyc - t0;
            Start = (rel == inject_at);
            if (rel == inject_at) begin
                Dir       = inj_dir;
                StepCount = inj_cnt;
                Period    = inj_per;
            end
            Abort = (rel == abort_at);
            @(negedge CLOCK_50);
            if (Step) begin
                step_q.push_back(rel);
                rem_q.push_back(int'(Remaining));
                dir_q.push_back(int'(StepDir));
                if (prev) consec++;
            end
            prev = Step;
            if (Busy) busy_hi++;
            if (Done) begin
                done_at      = rel;
                rem_at_done  = int'(Remaining);
                busy_at_done = int'(Busy);
            end
        end
        @(posedge CLOCK_50);
        #1;
        Start = 1'b0;
        Abort = 1'b0;
    endtask

    task automatic check_steps(input string tag);
        check_eq({tag, "_nsteps"}, step_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < step_q.size(); i++)
            check_eq($sformatf("%s_step%0d", tag, i + 1), step_q[i], exp_q[i]);
        check_eq({tag, "_consec"}, consec, 0);
    endtask

    initial begin
        RESET_N   = 1'b0;
        Start     = 1'b0;
        Abort     = 1'b0;
        Dir       = 1'b0;
        StepCount = '0;
        Period    = '0;

        // Reset state
        repeat (2) @(negedge CLOCK_50);
        check_eq("rst_outputs", {Step, StepDir, Busy, Done, Remaining}, 20'd0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        check_eq("idle_outputs", {Step, StepDir, Busy, Done, Remaining}, 20'd0);

        // Ramp profile: T=4, cur starts at 8.
        launch(1'b1, 16'd6, 20'd4);
        capture(-1, -1, 16'd0, 1'b0, 20'd0);
        exp_q = '{1, 7, 11, 15, 21, 29};
        check_steps("ramp");
        check_eq("ramp_done", done_at, 30);
        check_eq("ramp_busy_cycles", busy_hi, 29);
        check_eq("ramp_busy_at_done", busy_at_done, 0);
        for (int i = 0; i < rem_q.size(); i++)
            check_eq($sformatf("ramp_rem%0d", i + 1), rem_q[i], 6 - i);
        check_eq("ramp_rem_done", rem_at_done, 0);
        check_eq("ramp_dir", StepDir, 1'b1);

        // Zero count, with a Start injected during the Done cycle.
        launch(1'b0, 16'd0, 20'd4);
        capture(-1, 1, 16'd3, 1'b1, 20'd4);
        check_eq("zero_nsteps", step_q.size(), 0);
        check_eq("zero_done", done_at, 1);
        check_eq("zero_busy_cycles", busy_hi, 0);
        quiet = 0;
        repeat (4) begin
            @(negedge CLOCK_50);
            quiet += int'(Step) + int'(Busy) + int'(Done);
        end
        check_eq("zero_start_at_done_ignored", quiet, 0);

        // Constant spacing: T=10 is at least START_PERIOD.
        launch(1'b0, 16'd3, 20'd10);
        capture(-1, -1, 16'd0, 1'b0, 20'd0);
        exp_q = '{1, 11, 21};
        check_steps("const");
        check_eq("const_done", done_at, 22);
        check_eq("const_busy_cycles", busy_hi, 21);

        // Abort coincident with the 3rd step of a 6-step ramp run.
        launch(1'b1, 16'd6, 20'd4);
        capture(11, -1, 16'd0, 1'b0, 20'd0);
        exp_q = '{1, 7};
        check_steps("abort");
        check_eq("abort_done", done_at, 12);
        check_eq("abort_rem", rem_at_done, 4);
        check_eq("abort_busy_at_done", busy_at_done, 0);

        // Period=0 clamps to 2. A Start arriving while Busy must not disturb the run.
        launch(1'b0, 16'd8, 20'd0);
        capture(-1, 5, 16'd3, 1'b1, 20'd10);
        exp_q = '{1, 7, 11, 13, 15, 19, 25, 33};
        check_steps("clamp");
        check_eq("clamp_done", done_at, 34);
        check_eq("clamp_first_rem", (rem_q.size() > 0) ? rem_q[0] : -1, 8);
        check_eq("clamp_dir_ones", dir_q.sum(), 0);

        // Mid-run reset between the 2nd and 3rd steps.
        launch(1'b1, 16'd6, 20'd4);
        repeat (9) @(posedge CLOCK_50);
        #1;
        Start = 1'b0;
        check_eq("mrst_busy_before", Busy, 1'b1);
        check_eq("mrst_rem_before", Remaining, 16'd4);
        RESET_N = 1'b0;
        #1;
        check_eq("mrst_async_clear", {Step, StepDir, Busy, Done, Remaining}, 20'd0);
        quiet = 0;
        repeat (3) begin
            @(negedge CLOCK_50);
            quiet += int'(Step) + int'(Busy) + int'(Done);
        end
        RESET_N = 1'b1;
        repeat (12) begin
            @(negedge CLOCK_50);
            quiet += int'(Step) + int'(Busy) + int'(Done);
        end
        check_eq("mrst_quiet", quiet, 0);

        launch(1'b1, 16'd2, 20'd10);
        capture(-1, -1, 16'd0, 1'b0, 20'd0);
        exp_q = '{1, 11};
        check_steps("mrst_fresh");
        check_eq("mrst_fresh_done", done_at, 12);
        check_eq("mrst_fresh_dir", StepDir, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
